// File: rtl/drive_pkg.sv
// Shared definitions for the drive sequencer and its helpers.
//   drive_state_t   : sequencer state, 3-bit encoding visible on the state port
//   US_PER_MS       : clk_1mhz cycles per millisecond tick
//   DEFAULT_*       : cruise PWM period/duty, also used by the decelerator
package drive_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRUISE = 3'd1,
    DECEL  = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } drive_state_t;

  localparam int unsigned US_PER_MS           = 1000;
  localparam int unsigned DEFAULT_PERIOD_US   = 100;
  localparam int unsigned DEFAULT_CRUISE_DUTY = 75;

endpackage

// File: rtl/cruise_pwm_gen.sv
// Period/duty counter for cruise-speed PWM.
//   clk_1mhz  : 1 MHz clock
//   reset     : synchronous, active-high
//   en        : advance the period counter
//   clr       : synchronous clear of the period counter (wins over en)
//   pwm_level : unregistered level for the current count (cnt < CRUISE_DUTY)
// CRUISE_DUTY = 0 gives constant low; CRUISE_DUTY >= PERIOD_US gives constant high.
module cruise_pwm_gen
  import drive_pkg::*;
#(
  parameter int unsigned PERIOD_US   = DEFAULT_PERIOD_US,
  parameter int unsigned CRUISE_DUTY = DEFAULT_CRUISE_DUTY
) (
  input  logic clk_1mhz,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic pwm_level
);

  localparam int unsigned CNT_W = $clog2(PERIOD_US + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_1mhz) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_W'(PERIOD_US - 1)) cnt <= '0;
      else                              cnt <= cnt + 1'b1;
    end
  end

  assign pwm_level = (32'(cnt) < CRUISE_DUTY);

endmodule

// File: rtl/drive_sequencer.sv
// Speed sequencer for the RC drive motor: IDLE -> CRUISE -> DECEL -> HOLD -> IDLE,
// with FAULT reachable from estop, decel timeout or a decelerator that never starts.
//   clk_1mhz, reset            : 1 MHz clock, synchronous active-high reset
//   go, estop                  : synchronous level inputs
//   obstacle                   : asynchronous sensor, synchronised and debounced here
//   decel_done/active/pwm      : status and PWM from the decelerator block
//   decel_start, decel_clear   : decelerator start and synchronous re-arm
//   motor_pwm                  : registered motor drive
//   state, stopped             : current state encoding, high in IDLE/HOLD
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int unsigned PERIOD_US        = DEFAULT_PERIOD_US,
  parameter int unsigned CRUISE_DUTY      = DEFAULT_CRUISE_DUTY,
  parameter int unsigned DEBOUNCE_US      = 1000,
  parameter int unsigned STOP_HOLD_MS     = 500,
  parameter int unsigned DECEL_TIMEOUT_MS = 1500
) (
  input  logic       clk_1mhz,
  input  logic       reset,
  input  logic       go,
  input  logic       obstacle,
  input  logic       estop,
  input  logic       decel_done,
  input  logic       decel_active,
  input  logic       decel_pwm,
  output logic       decel_start,
  output logic       decel_clear,
  output logic       motor_pwm,
  output logic [2:0] state,
  output logic       stopped
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_US + 1);
  localparam int unsigned PS_W   = $clog2(US_PER_MS);
  localparam int unsigned MS_MAX = (STOP_HOLD_MS > DECEL_TIMEOUT_MS) ? STOP_HOLD_MS
                                                                      : DECEL_TIMEOUT_MS;
  localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

  drive_state_t     cur;
  logic             obs_s1, obs_s2, obstacle_q;
  logic [DB_W-1:0]  db_cnt;
  logic [PS_W-1:0]  presc;
  logic             ms_tick;
  logic [MS_W-1:0]  ms_cnt;
  logic [1:0]       ent_cnt;
  logic             active_seen;
  logic             pwm_level;
  logic             decel_timeout;
  logic             decel_no_start;

  assign state = cur;

  // Synchroniser and debounce: obstacle_q follows obs_s2 only after
  // DEBOUNCE_US consecutive cycles of disagreement.
  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      obs_s1     <= 1'b0;
      obs_s2     <= 1'b0;
      obstacle_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      obs_s1 <= obstacle;
      obs_s2 <= obs_s1;
      if (obs_s2 == obstacle_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_US - 1)) begin
        obstacle_q <= obs_s2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Free-running millisecond timebase.
  always_ff @(posedge clk_1mhz) begin
    if (reset || presc == PS_W'(US_PER_MS - 1)) presc <= '0;
    else                                        presc <= presc + 1'b1;
  end

  assign ms_tick = (presc == PS_W'(US_PER_MS - 1));

  cruise_pwm_gen #(
    .PERIOD_US   (PERIOD_US),
    .CRUISE_DUTY (CRUISE_DUTY)
  ) u_cruise_pwm (
    .clk_1mhz  (clk_1mhz),
    .reset     (reset),
    .en        (cur == CRUISE),
    .clr       (cur != CRUISE),
    .pwm_level (pwm_level)
  );

  // ent_cnt reaches 3 in the fourth DECEL cycle; no decel_active by then is a fault.
  assign decel_timeout  = (ms_cnt == MS_W'(DECEL_TIMEOUT_MS));
  assign decel_no_start = (ent_cnt == 2'd3) && !active_seen && !decel_active;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      cur         <= IDLE;
      motor_pwm   <= 1'b0;
      decel_start <= 1'b0;
      decel_clear <= 1'b1;
      stopped     <= 1'b0;
      ms_cnt      <= '0;
      ent_cnt     <= '0;
      active_seen <= 1'b0;
    end else if (estop) begin
      cur         <= FAULT;
      motor_pwm   <= 1'b0;
      decel_start <= 1'b0;
      decel_clear <= 1'b1;
      stopped     <= 1'b0;
    end else begin
      case (cur)
        IDLE: begin
          motor_pwm   <= 1'b0;
          decel_start <= 1'b0;
          decel_clear <= 1'b1;
          stopped     <= 1'b1;
          if (go && !obstacle_q) begin
            cur     <= CRUISE;
            stopped <= 1'b0;
          end
        end
        CRUISE: begin
          motor_pwm   <= pwm_level;
          decel_start <= 1'b0;
          decel_clear <= 1'b1;
          stopped     <= 1'b0;
          if (obstacle_q || !go) begin
            cur         <= DECEL;
            motor_pwm   <= 1'b0;
            decel_start <= 1'b1;
            decel_clear <= 1'b0;
            ms_cnt      <= '0;
            ent_cnt     <= '0;
            active_seen <= 1'b0;
          end
        end
        DECEL: begin
          motor_pwm   <= decel_pwm;
          decel_start <= 1'b1;
          decel_clear <= 1'b0;
          stopped     <= 1'b0;
          if (ms_tick && !decel_timeout) ms_cnt  <= ms_cnt + 1'b1;
          if (ent_cnt != 2'd3)           ent_cnt <= ent_cnt + 1'b1;
          if (decel_active)              active_seen <= 1'b1;
          if (decel_done) begin
            cur         <= HOLD;
            motor_pwm   <= 1'b0;
            decel_start <= 1'b0;
            decel_clear <= 1'b1;
            stopped     <= 1'b1;
            ms_cnt      <= '0;
          end else if (decel_timeout || decel_no_start) begin
            cur         <= FAULT;
            motor_pwm   <= 1'b0;
            decel_start <= 1'b0;
            decel_clear <= 1'b1;
          end
        end
        HOLD: begin
          motor_pwm   <= 1'b0;
          decel_start <= 1'b0;
          decel_clear <= 1'b1;
          stopped     <= 1'b1;
          if (ms_tick && ms_cnt != MS_W'(STOP_HOLD_MS)) ms_cnt <= ms_cnt + 1'b1;
          if (ms_cnt == MS_W'(STOP_HOLD_MS)) cur <= IDLE;
        end
        default: begin
          cur         <= FAULT;
          motor_pwm   <= 1'b0;
          decel_start <= 1'b0;
          decel_clear <= 1'b1;
          stopped     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer with a behavioural decelerator stub.
// Expected timing is derived from edge numbers counted since reset release:
// millisecond ticks are consumed at edges that are multiples of 1000.
module tb_drive_sequencer;

  localparam int PERIOD = 100;
  localparam int DUTY   = 75;
  localparam int DEB    = 10;
  localparam int HOLDMS = 2;
  localparam int TOMS   = 5;

  logic       clk_1mhz = 1'b0;
  logic       reset = 1'b1, go = 1'b0, obstacle = 1'b0, estop = 1'b0;
  logic       decel_done = 1'b0, decel_active = 1'b0, decel_pwm = 1'b0;
  logic       decel_start, decel_clear, motor_pwm, stopped;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e_c = 0;
  int act_dly = 1;
  int done_dly = -1;
  int st_cnt = 0;

  drive_sequencer #(
    .PERIOD_US        (PERIOD),
    .CRUISE_DUTY      (DUTY),
    .DEBOUNCE_US      (DEB),
    .STOP_HOLD_MS     (HOLDMS),
    .DECEL_TIMEOUT_MS (TOMS)
  ) dut (
    .clk_1mhz     (clk_1mhz),
    .reset        (reset),
    .go           (go),
    .obstacle     (obstacle),
    .estop        (estop),
    .decel_done   (decel_done),
    .decel_active (decel_active),
    .decel_pwm    (decel_pwm),
    .decel_start  (decel_start),
    .decel_clear  (decel_clear),
    .motor_pwm    (motor_pwm),
    .state        (state),
    .stopped      (stopped)
  );

  always #500 clk_1mhz = ~clk_1mhz;

  always @(posedge clk_1mhz) cyc <= reset ? 0 : cyc + 1;

  // Decelerator stub: active/done rise a programmable number of cycles after start.
  always @(posedge clk_1mhz) begin
    if (decel_clear) begin
      st_cnt       <= 0;
      decel_active <= 1'b0;
      decel_done   <= 1'b0;
      decel_pwm    <= 1'b0;
    end else if (decel_start) begin
      st_cnt       <= st_cnt + 1;
      decel_active <= (act_dly >= 0) && (st_cnt + 1 >= act_dly);
      decel_done   <= (done_dly >= 0) && (st_cnt + 1 >= done_dly);
      decel_pwm    <= ((act_dly >= 0) && (st_cnt + 1 >= act_dly)) ? 1'($urandom) : 1'b0;
    end
  end

  initial begin
    #100000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // n-th millisecond tick strictly after edge e
  function automatic int nth_tick(input int e, input int n);
    return (e / 1000 + n) * 1000;
  endfunction

  function automatic int cruise_exp(input int n);
    return (((n - e_c - 1) % PERIOD) < DUTY) ? 1 : 0;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; estop = 1'b0; obstacle = 1'b0;
    act_dly = 1; done_dly = -1;
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_pwm", motor_pwm, 0);
    chk("rst_start", decel_start, 0);
    chk("rst_clear", decel_clear, 1);
    chk("rst_stopped", stopped, 0);
    reset = 1'b0;
    step();
    chk("idle_state", state, 0);
    chk("idle_stopped", stopped, 1);
  endtask

  task automatic start_cruise();
    go = 1'b1;
    step();
    e_c = cyc;
    chk("cruise_entry", state, 1);
    chk("cruise_stopped", stopped, 0);
  endtask

  task automatic cruise_run(input int n);
    repeat (n) begin
      step();
      chk("cruise_state", state, 1);
      chk("cruise_pwm", motor_pwm, cruise_exp(cyc));
      chk("cruise_clear", decel_clear, 1);
    end
  endtask

  task automatic enter_decel_by_go(output int e);
    go = 1'b0;
    step();
    e = cyc;
    chk("decel_entry", state, 2);
    chk("decel_entry_start", decel_start, 1);
    chk("decel_entry_clear", decel_clear, 0);
  endtask

  task automatic estop_now(input string tag);
    estop = 1'b1;
    step();
    chk({tag, "_state"}, state, 4);
    chk({tag, "_pwm"}, motor_pwm, 0);
    chk({tag, "_start"}, decel_start, 0);
    estop = 1'b0;
    repeat (6) begin
      go = ~go;
      step();
      chk({tag, "_stuck"}, state, 4);
      chk({tag, "_stuck_pwm"}, motor_pwm, 0);
    end
  endtask

  initial begin
    int e, d, h, t5, idle_at, highs, g;
    logic prev_pwm;

    // Scenario 1: reset, cruise duty
    do_reset();
    start_cruise();
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      cruise_run(1);
      highs += int'(motor_pwm);
    end
    chk("duty_count_200", highs, 150);

    // Scenario 2: obstacle glitches do not leave CRUISE; a long one does
    obstacle = 1'b1; cruise_run(5); obstacle = 1'b0; cruise_run(20);
    g = $urandom_range(1, DEB - 1);
    obstacle = 1'b1; cruise_run(g); obstacle = 1'b0; cruise_run(20);
    cruise_run($urandom_range(0, 150));
    act_dly  = 1;
    d        = 3000 + $urandom_range(0, 500);
    done_dly = d;
    obstacle = 1'b1;
    cruise_run(DEB + 2);
    step();
    e = cyc;
    chk("obst_decel_state", state, 2);
    chk("obst_decel_start", decel_start, 1);
    chk("obst_decel_clear", decel_clear, 0);
    obstacle = 1'b0;

    // Scenario 3: decel PWM pass-through, HOLD, return via IDLE to CRUISE
    prev_pwm = decel_pwm;
    while (cyc < e + d) begin
      step();
      chk("decel_state", state, 2);
      chk("decel_pwm_follow", motor_pwm, prev_pwm);
      prev_pwm = decel_pwm;
    end
    step();
    h = cyc;
    chk("hold_state", state, 3);
    chk("hold_start", decel_start, 0);
    chk("hold_clear", decel_clear, 1);
    chk("hold_stopped", stopped, 1);
    chk("hold_pwm", motor_pwm, 0);
    idle_at = nth_tick(h, HOLDMS) + 1;
    wait_until(idle_at - 1);
    chk("hold_late_state", state, 3);
    step();
    chk("hold_exit_idle", state, 0);
    chk("hold_exit_stopped", stopped, 1);
    step();
    e_c = cyc;
    chk("idle_to_cruise", state, 1);
    cruise_run($urandom_range(5, 60));

    // Scenario 4: decelerator never starts
    act_dly = -1; done_dly = -1;
    enter_decel_by_go(e);
    wait_until(e + 5);
    chk("nostart_fault", state, 4);
    chk("nostart_pwm", motor_pwm, 0);
    chk("nostart_start", decel_start, 0);
    chk("nostart_clear", decel_clear, 1);
    repeat (4) begin go = ~go; step(); chk("nostart_stuck", state, 4); end
    do_reset();

    // Scenario 5a: active but never done -> timeout fault
    start_cruise();
    act_dly = $urandom_range(1, 3); done_dly = -1;
    cruise_run($urandom_range(10, 60));
    enter_decel_by_go(e);
    wait_until(e + 6);
    chk("active_ok_state", state, 2);
    t5 = nth_tick(e, TOMS);
    wait_until(t5);
    chk("timeout_pre", state, 2);
    step();
    chk("timeout_fault", state, 4);
    chk("timeout_pwm", motor_pwm, 0);
    do_reset();

    // Scenario 5b: done arrives in the timeout cycle -> HOLD wins
    start_cruise();
    cruise_run($urandom_range(10, 60));
    act_dly  = 1;
    done_dly = nth_tick(cyc + 1, TOMS) - (cyc + 1);
    enter_decel_by_go(e);
    t5 = nth_tick(e, TOMS);
    wait_until(t5);
    chk("tie_pre", state, 2);
    step();
    chk("tie_hold", state, 3);
    chk("tie_start", decel_start, 0);
    chk("tie_clear", decel_clear, 1);
    do_reset();

    // Scenario 6: estop in CRUISE, DECEL and HOLD
    start_cruise();
    cruise_run($urandom_range(1, 120));
    estop_now("estop_cruise");
    do_reset();

    start_cruise();
    cruise_run($urandom_range(1, 40));
    act_dly = 1; done_dly = -1;
    enter_decel_by_go(e);
    repeat ($urandom_range(2, 50)) step();
    chk("pre_estop_decel", state, 2);
    estop_now("estop_decel");
    do_reset();

    start_cruise();
    cruise_run($urandom_range(1, 40));
    act_dly = 1; done_dly = $urandom_range(5, 40);
    enter_decel_by_go(e);
    wait_until(e + done_dly + 1);
    chk("pre_estop_hold", state, 3);
    repeat ($urandom_range(1, 30)) step();
    estop_now("estop_hold");
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
